// File: rtl/minimig_autoconfig_pkg.sv
// Shared definitions for the autoconfig responder: chain slot indices,
// config-register byte offsets, default Zorro III mask and the FSM state type.
package minimig_autoconfig_pkg;

    // Number of chain slots and which of them are Zorro III boards.
    localparam int         NBOARDS_DEF = 6;
    localparam logic [5:0] Z3_MASK_DEF = 6'b011110;

    // Chain order: slot i serves ROM nibbles from base i*0x40.
    localparam logic [2:0] SLOT_Z2RAM  = 3'd0;
    localparam logic [2:0] SLOT_Z3RAM  = 3'd1;
    localparam logic [2:0] SLOT_Z3RAM2 = 3'd2;
    localparam logic [2:0] SLOT_Z3RAM3 = 3'd3;
    localparam logic [2:0] SLOT_ETH    = 3'd4;
    localparam logic [2:0] SLOT_SND    = 3'd5;

    // Config-space byte offsets that have write side effects.
    localparam logic [7:0] OFF_Z3_BASE = 8'h44;  // Z3 base, full 16-bit word
    localparam logic [7:0] OFF_Z2_BASE = 8'h48;  // Z2 base high nibble, configures
    localparam logic [7:0] OFF_Z2_LOW  = 8'h4A;  // Z2 base low nibble, latched only
    localparam logic [7:0] OFF_SHUTUP  = 8'h4C;  // board declines configuration

    // Responder states.
    typedef enum logic [2:0] {
        ST_SCAN = 3'd0,  // find next enabled slot
        ST_IDLE = 3'd1,  // serving the current slot
        ST_RD1  = 3'd2,  // ROM registering the address
        ST_RD2  = 3'd3,  // ROM output valid
        ST_HOLD = 3'd4,  // waiting for the master to drop cpu_req
        ST_DONE = 3'd5   // chain exhausted, config space reads as empty
    } state_t;

    // Zorro II base word: A23..A16 in the low byte, upper byte unused.
    function automatic logic [15:0] z2_base_word(input logic [3:0] hi,
                                                 input logic [3:0] lo);
        return {8'h00, hi, lo};
    endfunction

endpackage

// File: rtl/minimig_autoconfig_ctrl.sv
// Autoconfig responder: walks the board chain, serves ROM nibbles for the
// current slot, latches the base the OS assigns and advances on configure or
// shut-up. The nibble ROM sits beside this block and is fed by rom_addr.
//
// Bus handshake: the master raises cpu_req with cpu_rw/cpu_addr/cpu_wdata
// stable and keeps all of them held until it sees the one-cycle cpu_ack
// pulse; it must then drop cpu_req, and a new request is accepted no earlier
// than one cycle after the drop. cpu_rdata is valid in the cpu_ack cycle.
module minimig_autoconfig_ctrl
    import minimig_autoconfig_pkg::*;
#(
    parameter int                 NBOARDS = NBOARDS_DEF,
    parameter logic [NBOARDS-1:0] Z3_MASK = Z3_MASK_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NBOARDS-1:0]     board_en,
    input  logic                   cpu_req,
    input  logic                   cpu_rw,
    input  logic [6:0]             cpu_addr,
    input  logic [15:0]            cpu_wdata,
    output logic [15:0]            cpu_rdata,
    output logic                   cpu_ack,
    output logic [8:0]             rom_addr,
    input  logic [3:0]             rom_q,
    output logic [16*NBOARDS-1:0]  base_addr,
    output logic [NBOARDS-1:0]     cfg_valid,
    output logic                   config_done,
    output logic [2:0]             cur_board,
    output state_t                 dbg_state
);

    localparam logic [2:0] LAST_SLOT = 3'(NBOARDS - 1);

    state_t     state;
    logic [2:0] cur;
    logic [3:0] low_latch;   // Z2 base low nibble written at 0x4A
    logic       adv_pend;    // current slot configured or shut up, advance in HOLD

    logic       is_z3;
    logic       is_last;
    logic [7:0] wr_off;

    // Decode helpers for the current slot and access offset.
    always_comb begin
        is_z3   = Z3_MASK[cur];
        is_last = (cur == LAST_SLOT);
        wr_off  = {cpu_addr, 1'b0};
    end

    // ROM address is combinational; cpu_addr is held with cpu_req so it is
    // stable while the ROM pipeline runs.
    assign rom_addr  = {cur, cpu_addr[6:1]};
    assign cur_board = cur;
    assign dbg_state = state;

    // Responder FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_SCAN;
            cur         <= 3'd0;
            cpu_ack     <= 1'b0;
            cpu_rdata   <= 16'hFFFF;
            base_addr   <= '0;
            cfg_valid   <= '0;
            config_done <= 1'b0;
            low_latch   <= 4'h0;
            adv_pend    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;

            case (state)
                ST_SCAN: begin
                    // One slot per cycle; cpu_req is ignored until a slot is found.
                    if (board_en[cur]) begin
                        state <= ST_IDLE;
                    end else if (is_last) begin
                        state       <= ST_DONE;
                        config_done <= 1'b1;
                    end else begin
                        cur <= cur + 3'd1;
                    end
                end

                ST_IDLE: begin
                    if (cpu_req) begin
                        if (cpu_rw) begin
                            state <= ST_RD1;
                        end else begin
                            // Writes take effect and ack on the sampling edge.
                            cpu_ack <= 1'b1;
                            state   <= ST_HOLD;
                            case (wr_off)
                                OFF_Z2_LOW: begin
                                    if (!is_z3) low_latch <= cpu_wdata[15:12];
                                end
                                OFF_Z2_BASE: begin
                                    if (!is_z3) begin
                                        for (int i = 0; i < NBOARDS; i++) begin
                                            if (cur == 3'(i))
                                                base_addr[16*i +: 16] <=
                                                    z2_base_word(cpu_wdata[15:12], low_latch);
                                        end
                                        cfg_valid[cur] <= 1'b1;
                                        adv_pend       <= 1'b1;
                                    end
                                end
                                OFF_Z3_BASE: begin
                                    if (is_z3) begin
                                        for (int i = 0; i < NBOARDS; i++) begin
                                            if (cur == 3'(i))
                                                base_addr[16*i +: 16] <= cpu_wdata;
                                        end
                                        cfg_valid[cur] <= 1'b1;
                                        adv_pend       <= 1'b1;
                                    end
                                end
                                OFF_SHUTUP: begin
                                    adv_pend <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_RD1: begin
                    state <= ST_RD2;
                end

                ST_RD2: begin
                    // ROM nibble is passed through; an exhausted chain reads as all ones.
                    cpu_rdata <= config_done ? 16'hFFFF : {rom_q, 12'hFFF};
                    cpu_ack   <= 1'b1;
                    state     <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (!cpu_req) begin
                        if (adv_pend) begin
                            adv_pend <= 1'b0;
                            if (is_last) begin
                                state       <= ST_DONE;
                                config_done <= 1'b1;
                            end else begin
                                cur   <= cur + 3'd1;
                                state <= ST_SCAN;
                            end
                        end else begin
                            state <= config_done ? ST_DONE : ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    // Reads still take the ROM path timing; writes are acked only.
                    if (cpu_req) begin
                        if (cpu_rw) begin
                            state <= ST_RD1;
                        end else begin
                            cpu_ack <= 1'b1;
                            state   <= ST_HOLD;
                        end
                    end
                end

                default: begin
                    state <= ST_SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// Bench for minimig_autoconfig_ctrl: a two-stage ROM model, read/write driver
// tasks, and a read-data scoreboard fed by the read driver.
module tb_minimig_autoconfig_ctrl;
  import minimig_autoconfig_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  board_en = 6'b111111;
  logic        cpu_req = 1'b0;
  logic        cpu_rw = 1'b0;
  logic [6:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ack;
  logic [8:0]  rom_addr;
  logic [3:0]  rom_q = 4'h0;
  logic [95:0] base_addr;
  logic [5:0]  cfg_valid;
  logic        config_done;
  logic [2:0]  cur_board;
  state_t      dbg_state;

  minimig_autoconfig_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .board_en    (board_en),
    .cpu_req     (cpu_req),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .base_addr   (base_addr),
    .cfg_valid   (cfg_valid),
    .config_done (config_done),
    .cur_board   (cur_board),
    .dbg_state   (dbg_state)
  );

  // ---------------- ROM model: address register, then output register ----------------
  function automatic logic [3:0] rom_val(input logic [8:0] a);
    case (a)
      9'd0:    return 4'hE;
      9'd4:    return 4'hE;
      9'd128:  return 4'hA;
      default: return a[3:0] ^ 4'h5;
    endcase
  endfunction

  logic [8:0] rom_a_loc = '0;
  always @(posedge clk) begin
    rom_a_loc <= rom_addr;
    rom_q     <= rom_val(rom_a_loc);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard: read data ----------------
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    #1;
    if (cpu_ack && cpu_rw && cpu_req) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        check("sb_rdata", {16'h0, cpu_rdata}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input logic [5:0] en);
    @(negedge clk);
    reset_n  = 1'b0;
    cpu_req  = 1'b0;
    board_en = en;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_state(input state_t st, output int cyc);
    bit hit;
    hit = 0;
    cyc = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (dbg_state == st) hit = 1;
    end
    if (!hit) check("wait_state_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [7:0] off, input logic [15:0] exp);
    int cyc;
    bit got;
    exp_q.push_back(exp);
    @(negedge clk);
    cpu_addr = off[7:1];
    cpu_rw   = 1'b1;
    cpu_req  = 1'b1;
    got = 0;
    cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_ack) got = 1;
    end
    check("rd_ack_seen", {31'd0, got}, 32'd1);
    if (got) check("rd_latency", cyc, 32'd3);
    else void'(exp_q.pop_front());
    @(negedge clk);
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check("rd_ack_one_cycle", {31'd0, cpu_ack}, 32'd0);
  endtask

  task automatic do_write(input logic [7:0] off, input logic [15:0] data);
    int cyc;
    bit got;
    @(negedge clk);
    cpu_addr  = off[7:1];
    cpu_wdata = data;
    cpu_rw    = 1'b0;
    cpu_req   = 1'b1;
    got = 0;
    cyc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_ack) got = 1;
    end
    check("wr_ack_seen", {31'd0, got}, 32'd1);
    if (got) check("wr_latency", cyc, 32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int cyc;
    int acks;

    // Phase 1: all slots enabled, reset values.
    apply_reset(6'b111111);
    reset_n = 1'b0;
    #1;
    check("rst_ack",    {31'd0, cpu_ack}, 32'd0);
    check("rst_rdata",  {16'd0, cpu_rdata}, 32'hFFFF);
    check("rst_base",   base_addr[31:0], 32'd0);
    check("rst_cfgv",   {26'd0, cfg_valid}, 32'd0);
    check("rst_done",   {31'd0, config_done}, 32'd0);
    check("rst_cur",    {29'd0, cur_board}, 32'd0);
    check("rst_state",  {29'd0, dbg_state}, {29'd0, ST_SCAN});
    @(negedge clk);
    reset_n = 1'b1;
    wait_state(ST_IDLE, cyc);

    do_read(8'h00, 16'hEFFF);
    do_read(8'h10, 16'hEFFF);
    do_read(8'h08, {rom_val(9'd2), 12'hFFF});

    // Configure Z2 slot 0 at $200000.
    do_write(8'h4A, 16'h0000);
    do_write(8'h48, 16'h2000);
    check("z2_base",  {16'd0, base_addr[15:0]}, 32'h0020);
    check("z2_cfgv",  {26'd0, cfg_valid}, 32'b000001);
    wait_state(ST_IDLE, cyc);
    check("z2_adv_cur", {29'd0, cur_board}, 32'd1);

    // Slot 1 is Z3: the Z2 offset is acked without effect, then 0x44 configures.
    do_write(8'h48, 16'h1234);
    check("z3_ign_cfgv", {26'd0, cfg_valid}, 32'b000001);
    check("z3_ign_base", {16'd0, base_addr[31:16]}, 32'd0);
    wait_state(ST_IDLE, cyc);
    check("z3_ign_cur", {29'd0, cur_board}, 32'd1);
    do_write(8'h44, 16'h4000);
    check("z3_base", {16'd0, base_addr[31:16]}, 32'h4000);
    check("z3_cfgv", {26'd0, cfg_valid}, 32'b000011);
    wait_state(ST_IDLE, cyc);
    check("z3_adv_cur", {29'd0, cur_board}, 32'd2);
    do_read(8'h00, 16'hAFFF);

    // Phase 2: sparse chain, low nibble latch, skip timing, shut-up.
    apply_reset(6'b100001);
    wait_state(ST_IDLE, cyc);
    do_write(8'h4A, 16'h5000);
    do_write(8'h48, 16'hE000);
    check("z2_lownib_base", {16'd0, base_addr[15:0]}, 32'h00E5);
    wait_state(ST_IDLE, cyc);
    check("skip_cycles", cyc, 32'd6);
    check("skip_cur", {29'd0, cur_board}, 32'd5);
    do_write(8'h4C, 16'hFFFF);
    wait_state(ST_DONE, cyc);
    check("shut_done", {31'd0, config_done}, 32'd1);
    check("shut_cfgv", {26'd0, cfg_valid}, 32'b000001);
    check("shut_base", {16'd0, base_addr[95:80]}, 32'd0);
    check("shut_cur",  {29'd0, cur_board}, 32'd5);
    do_read(8'h00, 16'hFFFF);
    do_write(8'h44, 16'h7700);
    check("done_wr_ign", {16'd0, base_addr[95:80]}, 32'd0);
    wait_state(ST_DONE, cyc);
    check("done_cur_hold", {29'd0, cur_board}, 32'd5);

    // Phase 3: empty chain.
    apply_reset(6'b000000);
    wait_state(ST_DONE, cyc);
    check("empty_cycles", cyc, 32'd6);
    check("empty_done", {31'd0, config_done}, 32'd1);
    check("empty_cur", {29'd0, cur_board}, 32'd5);

    // Phase 4: reset lands during RD1, pending ack is lost.
    apply_reset(6'b111111);
    wait_state(ST_IDLE, cyc);
    do_write(8'h4A, 16'h3000);
    do_write(8'h48, 16'h3000);
    wait_state(ST_IDLE, cyc);
    @(negedge clk);
    cpu_addr = 7'd0;
    cpu_rw   = 1'b1;
    cpu_req  = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rd1", {29'd0, dbg_state}, {29'd0, ST_RD1});
    reset_n = 1'b0;
    #1;
    acks = 0;
    check("mid_cur",  {29'd0, cur_board}, 32'd0);
    check("mid_cfgv", {26'd0, cfg_valid}, 32'd0);
    check("mid_base", {16'd0, base_addr[15:0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (cpu_ack) acks++;
    end
    @(negedge clk);
    cpu_req = 1'b0;
    reset_n = 1'b1;
    wait_state(ST_IDLE, cyc);
    check("mid_no_ack", acks, 32'd0);
    do_read(8'h00, 16'hEFFF);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
